// File: rtl/pixel_ray_if.sv
// Pixel/ray bus between the scheduler, the ray generator and the consumer.
//   issue    : x_out, y_out, issue_valid_out       (scheduler -> ray generator)
//   return   : dir_{x,y,z}_in, dir_valid_in        (ray generator -> scheduler)
//   downstream: ray_{x,y,z}_out, px_{x,y}_out,
//               ray_valid_out / ray_ready_in       (scheduler <-> consumer)
// master = scheduler side, slave = environment side.
interface pixel_ray_if;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        issue_valid_out;
  logic [31:0] dir_x_in;
  logic [31:0] dir_y_in;
  logic [31:0] dir_z_in;
  logic        dir_valid_in;
  logic [31:0] ray_x_out;
  logic [31:0] ray_y_out;
  logic [31:0] ray_z_out;
  logic [10:0] px_x_out;
  logic [9:0]  px_y_out;
  logic        ray_valid_out;
  logic        ray_ready_in;

  modport master (
    output x_out, y_out, issue_valid_out,
    input  dir_x_in, dir_y_in, dir_z_in, dir_valid_in,
    output ray_x_out, ray_y_out, ray_z_out, px_x_out, px_y_out, ray_valid_out,
    input  ray_ready_in
  );

  modport slave (
    input  x_out, y_out, issue_valid_out,
    output dir_x_in, dir_y_in, dir_z_in, dir_valid_in,
    input  ray_x_out, ray_y_out, ray_z_out, px_x_out, px_y_out, ray_valid_out,
    output ray_ready_in
  );
endinterface

// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel scheduler for a ray generator pipeline.
// Issues one pixel per cycle while credit is available, tags each issued
// pixel in a FIFO, pairs returning directions with their tags into a result
// FIFO, and presents the result FIFO head downstream with valid/ready.
// Credit covers every slot between issue and downstream accept, so neither
// FIFO can overflow regardless of the return latency.
// Ports:
//   clk_in, rst_in  : clock, synchronous active-high reset
//   start_in        : frame start (honoured in IDLE only)
//   busy_out        : frame in progress
//   frame_done_out  : pulse on accept of the last pixel
//   err_out         : sticky, return beat with no outstanding tag
//   bus             : pixel_ray_if master (issue, return, downstream)
module pixel_ray_scheduler #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 384,
  parameter int DEPTH  = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  output logic         busy_out,
  output logic         frame_done_out,
  output logic         err_out,
  pixel_ray_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    logic [10:0] px;
    logic [9:0]  py;
  } res_t;

  state_t        state_q, state_d;
  logic [10:0]   sx_q, sx_d;
  logic [9:0]    sy_q, sy_d;
  logic [10:0]   xo_q;
  logic [9:0]    yo_q;
  logic          iv_q;
  logic [CW-1:0] cred_q;
  logic          err_q;
  logic          done;

  // tag FIFO: {y, x} of every pixel in flight in the ray generator
  logic [20:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wp_q, tag_rp_q;
  logic [AW:0]   tag_cnt_q;

  // result FIFO: returned direction plus its pixel tag
  res_t          res_mem [DEPTH];
  logic [AW-1:0] res_wp_q, res_rp_q;
  logic [AW:0]   res_cnt_q;

  logic issue, hs, tag_pop, spur, last_px, rv, final_hs, start_acc;
  res_t head;

  assign start_acc = (state_q == IDLE) && start_in;
  assign issue     = (state_q == ISSUE) && (cred_q != '0);
  assign last_px   = (sx_q == 11'(WIDTH - 1)) && (sy_q == 10'(HEIGHT - 1));
  assign rv        = (res_cnt_q != '0);
  assign head      = res_mem[res_rp_q];
  assign hs        = rv && bus.ray_ready_in;
  assign tag_pop   = bus.dir_valid_in && (tag_cnt_q != '0);
  assign spur      = bus.dir_valid_in && (tag_cnt_q == '0);
  // pixels are unique per frame and leave in issue order, so the last
  // pixel's coordinates at the head during DRAIN mark the end of frame
  assign final_hs  = (state_q == DRAIN) && hs &&
                     (head.px == 11'(WIDTH - 1)) && (head.py == 10'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = ISSUE;
        sx_d    = '0;
        sy_d    = '0;
      end
      ISSUE: if (issue) begin
        if (last_px) begin
          state_d = DRAIN;
        end else if (sx_q == 11'(WIDTH - 1)) begin
          sx_d = '0;
          sy_d = sy_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      DRAIN: if (final_hs) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      xo_q      <= '0;
      yo_q      <= '0;
      iv_q      <= 1'b0;
      cred_q    <= CW'(DEPTH);
      err_q     <= 1'b0;
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      tag_cnt_q <= '0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      iv_q    <= issue;
      if (issue) begin
        xo_q <= sx_q;
        yo_q <= sy_q;
      end
      case ({issue, hs})
        2'b10:   cred_q <= cred_q - 1'b1;
        2'b01:   cred_q <= cred_q + 1'b1;
        default: cred_q <= cred_q;
      endcase
      // a spurious beat in the start cycle still leaves the flag set
      if (start_acc) err_q <= 1'b0;
      if (spur)      err_q <= 1'b1;

      if (issue)   tag_wp_q <= tag_wp_q + 1'b1;
      if (tag_pop) tag_rp_q <= tag_rp_q + 1'b1;
      case ({issue, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase

      if (tag_pop) res_wp_q <= res_wp_q + 1'b1;
      if (hs)      res_rp_q <= res_rp_q + 1'b1;
      case ({tag_pop, hs})
        2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
        2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  // storage arrays carry no reset; the pointers and counts define content
  always_ff @(posedge clk_in) begin
    if (issue)   tag_mem[tag_wp_q] <= {sy_q, sx_q};
    if (tag_pop) res_mem[res_wp_q] <= '{dx: bus.dir_x_in, dy: bus.dir_y_in,
                                        dz: bus.dir_z_in,
                                        px: tag_mem[tag_rp_q][10:0],
                                        py: tag_mem[tag_rp_q][20:11]};
  end

  assign bus.x_out           = xo_q;
  assign bus.y_out           = yo_q;
  assign bus.issue_valid_out = iv_q;
  assign bus.ray_valid_out   = rv;
  // data forced to zero when empty so stale storage never shows
  assign bus.ray_x_out       = rv ? head.dx : '0;
  assign bus.ray_y_out       = rv ? head.dy : '0;
  assign bus.ray_z_out       = rv ? head.dz : '0;
  assign bus.px_x_out        = rv ? head.px : '0;
  assign bus.px_y_out        = rv ? head.py : '0;
  assign busy_out            = (state_q != IDLE);
  assign frame_done_out      = done;
  assign err_out             = err_q;
endmodule

// File: tb/tb_pixel_ray_scheduler.sv
module tb_pixel_ray_scheduler;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err;

  always #5 clk = ~clk;

  pixel_ray_if bus();

  pixel_ray_scheduler #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .busy_out(busy), .frame_done_out(done), .err_out(err), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dirf(input logic [10:0] x, input logic [9:0] y,
                                       input logic [7:0] k);
    return {k, 3'b000, y, x};
  endfunction

  typedef struct {logic [10:0] x; logic [9:0] y; int due;} fl_t;
  typedef struct {logic [10:0] x; logic [9:0] y;} px_t;

  // environment state
  int  ready_mode = 0;
  int  lat_lo = 30, lat_hi = 30;
  bit  spur_req = 0;
  fl_t pipe[$];
  px_t sb[$];
  int  cyc = 0, last_due = 0;
  int  issue_cnt, hs_cnt, done_cnt, iss_cyc, hs_cyc;
  bit  cred_bad;
  logic [10:0] mx;
  logic [9:0]  my;
  bit  prev_hold, prev_done;
  logic [116:0] prev_snap;

  // ray generator model (in-order, per-beat latency) and ready driver
  initial begin
    bus.dir_valid_in = 1'b0;
    bus.dir_x_in = '0; bus.dir_y_in = '0; bus.dir_z_in = '0;
    bus.ray_ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.ray_ready_in = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        fl_t f;
        f = pipe.pop_front();
        bus.dir_valid_in = 1'b1;
        bus.dir_x_in = dirf(f.x, f.y, 8'd1);
        bus.dir_y_in = dirf(f.x, f.y, 8'd2);
        bus.dir_z_in = dirf(f.x, f.y, 8'd3);
      end else if (spur_req) begin
        bus.dir_valid_in = 1'b1;
        bus.dir_x_in = 32'hDEAD0001; bus.dir_y_in = 32'hDEAD0002; bus.dir_z_in = 32'hDEAD0003;
      end else begin
        bus.dir_valid_in = 1'b0;
      end
    end
  end

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    px_t e;
    int  lat, due;
    if (rst) begin
      prev_hold = 0;
      prev_done = 0;
    end else begin
      if (bus.issue_valid_out) begin
        chk("issue_xy", {bus.x_out, bus.y_out}, {mx, my});
        sb.push_back('{mx, my});
        if (mx == 11'(W - 1)) begin mx = '0; my = my + 1'b1; end
        else mx = mx + 1'b1;
        lat = int'($urandom_range(lat_lo, lat_hi));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pipe.push_back('{bus.x_out, bus.y_out, due});
        issue_cnt++;
        iss_cyc = cyc;
      end
      if (prev_hold)
        chk("hold_stable", {bus.ray_x_out, bus.ray_y_out, bus.ray_z_out,
                            bus.px_x_out, bus.px_y_out}, prev_snap);
      if (prev_done) chk("busy_fall", busy, 1'b0);
      if (done) begin
        done_cnt++;
        chk("done_last", {bus.ray_valid_out, bus.ray_ready_in, bus.px_x_out, bus.px_y_out},
            {2'b11, 11'(W - 1), 10'(H - 1)});
      end
      if (bus.ray_valid_out && bus.ray_ready_in) begin
        if (sb.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("ray", {bus.px_x_out, bus.px_y_out, bus.ray_x_out, bus.ray_y_out, bus.ray_z_out},
              {e.x, e.y, dirf(e.x, e.y, 8'd1), dirf(e.x, e.y, 8'd2), dirf(e.x, e.y, 8'd3)});
        end
        hs_cnt++;
        hs_cyc = cyc;
      end
      if (issue_cnt - hs_cnt > D || issue_cnt - hs_cnt < 0) cred_bad = 1;
      prev_done = done;
      prev_hold = bus.ray_valid_out && !bus.ray_ready_in;
      prev_snap = {bus.ray_x_out, bus.ray_y_out, bus.ray_z_out, bus.px_x_out, bus.px_y_out};
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_stats();
    issue_cnt = 0; hs_cnt = 0; done_cnt = 0; cred_bad = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    mx = '0; my = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    chk(nm, done_cnt >= target, 1'b1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, {bus.issue_valid_out, bus.ray_valid_out, busy, done, err,
                        bus.x_out, bus.y_out}, '0);
    chk({nm, "_data"}, {bus.ray_x_out, bus.ray_y_out, bus.ray_z_out,
                        bus.px_x_out, bus.px_y_out}, '0);
  endtask

  typedef struct {int rdy; int lo; int hi; int frames; int exp_rays; int exp_done;} vec_t;
  vec_t tbl[4];

  initial begin
    int n;
    tbl[0] = '{1, 30, 30, 1, W*H,     1};  // smoke
    tbl[1] = '{2, 1,  40, 6, 6*W*H,   6};  // random latency and ready
    tbl[2] = '{1, 1,  1,  2, 2*W*H,   2};  // minimum latency
    tbl[3] = '{2, 1,  3,  4, 4*W*H,   4};  // short random latency

    rst = 1'b1; start = 1'b0;
    mx = '0; my = '0;
    clear_stats();
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      ready_mode = tbl[i].rdy; lat_lo = tbl[i].lo; lat_hi = tbl[i].hi;
      clear_stats();
      tick();
      for (int f = 0; f < tbl[i].frames; f++) begin
        pulse_start();
        wait_done($sformatf("vec%0d_done_timeout", i), f + 1, 3000);
      end
      repeat (3) tick();
      chk($sformatf("vec%0d_rays", i), hs_cnt, tbl[i].exp_rays);
      chk($sformatf("vec%0d_issues", i), issue_cnt, tbl[i].exp_rays);
      chk($sformatf("vec%0d_done_cnt", i), done_cnt, tbl[i].exp_done);
      chk($sformatf("vec%0d_err_busy", i), {err, busy}, 2'b00);
      chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
      chk($sformatf("vec%0d_credit", i), cred_bad, 1'b0);
    end

    // backpressure: credit stops issue at DEPTH, nothing lost
    ready_mode = 0; lat_lo = 30; lat_hi = 30;
    clear_stats();
    tick();
    pulse_start();
    repeat (80) tick();
    chk("bp_issues", issue_cnt, D);
    chk("bp_valid_held", {bus.ray_valid_out, bus.issue_valid_out}, 2'b10);
    chk("bp_sb", sb.size(), D);
    // one accept at credit 0: exactly one further issue, strictly later
    ready_mode = 1;
    tick();
    ready_mode = 0;
    repeat (10) tick();
    chk("simul_issues", issue_cnt, D + 1);
    chk("simul_hs", hs_cnt, 1);
    chk("simul_order", iss_cyc > hs_cyc, 1'b1);
    ready_mode = 1;
    wait_done("bp_done_timeout", 1, 2000);
    repeat (2) tick();
    chk("bp_rays", hs_cnt, W*H);
    chk("bp_err_credit", {err, cred_bad}, 2'b00);

    // spurious return in IDLE
    spur_req = 1;
    tick();
    spur_req = 0;
    repeat (3) tick();
    chk("spur_err", err, 1'b1);
    chk("spur_no_ray", {bus.ray_valid_out, busy}, 2'b00);
    clear_stats();
    pulse_start();
    chk("spur_err_clear", err, 1'b0);
    wait_done("spur_done_timeout", 1, 2000);
    repeat (2) tick();
    chk("spur_rays", hs_cnt, W*H);

    // reset mid-frame after 5 issues
    clear_stats();
    pulse_start();
    n = 0;
    while (issue_cnt < 5 && n < 200) begin tick(); n++; end
    chk("mid_issue5", issue_cnt >= 5, 1'b1);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    sb.delete();
    clear_stats();
    n = 0;
    while (pipe.size() > 0 && n < 200) begin tick(); n++; end
    repeat (2) tick();
    chk("midrst_late_err", {err, bus.ray_valid_out}, 2'b10);
    clear_stats();
    pulse_start();
    wait_done("clean_done_timeout", 1, 2000);
    repeat (2) tick();
    chk("clean_rays", hs_cnt, W*H);
    chk("clean_err_sb", {err, sb.size() == 0, cred_bad}, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
